conv_core: RTL and testbench

Convolution engine instantiated under the convolution AIP wrapper, between its input memories (MemIn0 holding x, MemIn1 holding y) and its output memory (MemOut0 holding z). On `start` it computes the full linear convolution z[n] = Σ x[k]·y[n−k] for the sizes in the configuration register. It reads operands through synchronous-read memory ports and writes each result word to the output memory. It reports `busy_out` to the status register and `done_out` to the interrupt logic.

---
 rtl/conv_core.sv | 197 +++++++++++++++++++
 tb/tb_conv_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv_core.sv
// conv_core: full linear convolution z[n] = sum x[k]*y[n-k] over two
// synchronous-read input memories, writing one result word per output index.
module conv_core #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int ADDR_WIDTH_OUT = 6
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      start,
  // "config" is a reserved word in SystemVerilog, hence the suffix
  input  logic [DATA_WIDTH-1:0]     config_in,
  output logic [ADDR_WIDTH-1:0]     memX_addr,
  input  logic [DATA_WIDTH-1:0]     dataX,
  output logic [ADDR_WIDTH-1:0]     memY_addr,
  input  logic [DATA_WIDTH-1:0]     dataY,
  output logic [ADDR_WIDTH_OUT-1:0] memZ_addr,
  output logic [DATA_WIDTH-1:0]     dataZ,
  output logic                      writeZ,
  output logic                      busy_out,
  output logic                      done_out
);

  typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, WRITE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [5:0]                  size_x_q, size_x_d;
  logic [5:0]                  size_y_q, size_y_d;
  logic [5:0]                  n_q, n_d;
  logic [6:0]                  k_q, k_d;
  logic [6:0]                  kmax_q, kmax_d;
  logic [DATA_WIDTH-1:0]       acc_q, acc_d;
  logic                        pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]       x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0]       y_addr_q, y_addr_d;
  logic [ADDR_WIDTH_OUT-1:0]   z_addr_q, z_addr_d;
  logic [DATA_WIDTH-1:0]       z_data_q, z_data_d;
  logic                        write_q, write_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Index arithmetic is done 7 bits wide so n+1 and sizeX+sizeY never wrap.
  logic [6:0] n_ext, sx_ext, sy_ext;
  logic [6:0] kmin, kmax, last_n, k_plus, y_first, y_next;
  logic [5:0] cfg_sx, cfg_sy;
  logic       cfg_valid;
  logic [DATA_WIDTH-1:0] prod;
  logic       unused_bits;

  assign n_ext   = {1'b0, n_q};
  assign sx_ext  = {1'b0, size_x_q};
  assign sy_ext  = {1'b0, size_y_q};
  assign kmin    = (n_ext + 7'd1 > sy_ext) ? (n_ext + 7'd1 - sy_ext) : 7'd0;
  assign kmax    = (n_ext < sx_ext - 7'd1) ? n_ext : (sx_ext - 7'd1);
  assign last_n  = sx_ext + sy_ext - 7'd2;
  assign k_plus  = k_q + 7'd1;
  assign y_first = n_ext - kmin;
  assign y_next  = n_ext - k_plus;

  assign cfg_sx    = config_in[5:0];
  assign cfg_sy    = config_in[11:6];
  assign cfg_valid = (cfg_sx != 6'd0) && (cfg_sx <= 6'd32) &&
                     (cfg_sy != 6'd0) && (cfg_sy <= 6'd32);

  // Low DATA_WIDTH bits of the unsigned product; the accumulator wraps.
  assign prod = dataX * dataY;

  assign unused_bits = ^{config_in[DATA_WIDTH-1:12], y_first[6:ADDR_WIDTH],
                         y_next[6:ADDR_WIDTH], kmin[6:ADDR_WIDTH],
                         k_plus[6:ADDR_WIDTH]};

  // Next-state and next-output logic; every output is registered with the state.
  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    n_d      = n_q;
    k_d      = k_q;
    kmax_d   = kmax_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    x_addr_d = x_addr_q;
    y_addr_d = y_addr_q;
    z_addr_d = z_addr_q;
    z_data_d = z_data_q;
    write_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          size_x_d = cfg_sx;
          size_y_d = cfg_sy;
          if (cfg_valid) begin
            n_d     = 6'd0;
            busy_d  = 1'b1;
            state_d = SETUP;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        k_d      = kmin;
        kmax_d   = kmax;
        acc_d    = '0;
        pend_d   = 1'b0;
        x_addr_d = kmin[ADDR_WIDTH-1:0];
        y_addr_d = y_first[ADDR_WIDTH-1:0];
        state_d  = READ;
      end
      READ: begin
        // Data for the address issued last cycle arrives now.
        pend_d = 1'b1;
        if (pend_q) acc_d = acc_q + prod;
        if (k_q == kmax_q) begin
          state_d = DRAIN;
        end else begin
          k_d      = k_plus;
          x_addr_d = k_plus[ADDR_WIDTH-1:0];
          y_addr_d = y_next[ADDR_WIDTH-1:0];
        end
      end
      DRAIN: begin
        pend_d   = 1'b0;
        z_addr_d = n_q;
        z_data_d = acc_q + prod;
        write_d  = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        if (n_ext == last_n) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          n_d     = n_q + 6'd1;
          state_d = SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q  <= IDLE;
      size_x_q <= '0;
      size_y_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      z_addr_q <= '0;
      z_data_q <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_x_q <= size_x_d;
      size_y_q <= size_y_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      x_addr_q <= x_addr_d;
      y_addr_q <= y_addr_d;
      z_addr_q <= z_addr_d;
      z_data_q <= z_data_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign memX_addr = x_addr_q;
  assign memY_addr = y_addr_q;
  assign memZ_addr = z_addr_q;
  assign dataZ     = z_data_q;
  assign writeZ    = write_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_conv_core.sv
// tb_conv_core: drives conv_core against behavioural x/y memories and checks
// every cycle of each job against a direct convolution model.
module tb_conv_core;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg = '0;
  logic [4:0]  memX_addr, memY_addr;
  logic [31:0] dataX = '0, dataY = '0;
  logic [5:0]  memZ_addr;
  logic [31:0] dataZ;
  logic        writeZ, busy_out, done_out;

  logic [31:0] memx [32];
  logic [31:0] memy [32];

  int total = 0;
  int bad = 0;

  conv_core dut (
    .clk(clk), .rst_a(rst_a), .start(start), .config_in(cfg),
    .memX_addr(memX_addr), .dataX(dataX),
    .memY_addr(memY_addr), .dataY(dataY),
    .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read input memories: data valid the cycle after the address.
  always @(posedge clk) begin
    dataX <= memx[memX_addr];
    dataY <= memy[memY_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Run one job from start to done, checking each cycle. Start is re-pulsed
  // at cycle 'glitch' (while busy) and on the done cycle; both must be ignored.
  task automatic run_job(input int sx, input int sy, input int glitch);
    logic [31:0] exp_z [64];
    int exp_wc [64];
    int nz, s, done_cyc, c, widx, kmin, kmax;
    bit valid;
    valid = (sx >= 1 && sx <= 32 && sy >= 1 && sy <= 32);
    nz = valid ? sx + sy - 1 : 0;
    s = 1;
    for (int n = 0; n < nz; n++) begin
      exp_z[n] = '0;
      for (int k = 0; k < sx; k++)
        if (n - k >= 0 && n - k < sy) exp_z[n] = exp_z[n] + memx[k] * memy[n-k];
      kmin = (n - sy + 1 > 0) ? n - sy + 1 : 0;
      kmax = (n < sx - 1) ? n : sx - 1;
      exp_wc[n] = s + (kmax - kmin + 1) + 2;
      s += (kmax - kmin + 1) + 3;
    end
    done_cyc = valid ? s : 1;
    @(negedge clk);
    cfg = {20'd0, sy[5:0], sx[5:0]};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg = $urandom;
    c = 1;
    widx = 0;
    forever begin
      if (writeZ) begin
        check("write_index_in_range", 64'(widx < nz), 64'd1);
        check("write_addr", 64'(memZ_addr), 64'(widx));
        check("write_data", 64'(dataZ), 64'(exp_z[widx]));
        check("write_cycle", 64'(c), 64'(exp_wc[widx]));
        widx++;
      end
      check("busy", 64'(busy_out), 64'(valid && c < done_cyc));
      check("done", 64'(done_out), 64'(c == done_cyc));
      if (c == done_cyc) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_busy", 64'(busy_out), 64'd0);
        check("start_at_done_done", 64'(done_out), 64'd0);
        check("start_at_done_write", 64'(writeZ), 64'd0);
        break;
      end
      start = (c == glitch);
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    check("write_count", 64'(widx), 64'(nz));
    $display("job sx=%0d sy=%0d writes=%0d done_cycle=%0d", sx, sy, widx, done_cyc);
  endtask

  task automatic load_3x2();
    for (int i = 0; i < 32; i++) begin memx[i] = $urandom; memy[i] = $urandom; end
    memx[0] = 1; memx[1] = 2; memx[2] = 3;
    memy[0] = 1; memy[1] = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin memx[i] = '0; memy[i] = '0; end
    repeat (2) @(negedge clk);
    check("rst_memX_addr", 64'(memX_addr), 64'd0);
    check("rst_memY_addr", 64'(memY_addr), 64'd0);
    check("rst_memZ_addr", 64'(memZ_addr), 64'd0);
    check("rst_dataZ", 64'(dataZ), 64'd0);
    check("rst_writeZ", 64'(writeZ), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    rst_a = 1'b0;

    // 1x1
    memx[0] = 7; memy[0] = 6;
    run_job(1, 1, 0);

    // 3x2 -> [1,3,5,3]
    load_3x2();
    run_job(3, 2, 0);

    // 32x32 of ones
    for (int i = 0; i < 32; i++) begin memx[i] = 1; memy[i] = 1; end
    run_job(32, 32, 100);

    // Wrap-around arithmetic
    memx[0] = 32'hFFFF_FFFF; memx[1] = 32'h8000_0000; memy[0] = 2;
    run_job(2, 1, 0);

    // Invalid sizes
    run_job(0, 5, 0);
    run_job(4, 33, 0);

    // Random sizes and data
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 32; i++) begin memx[i] = $urandom; memy[i] = $urandom; end
      run_job(int'($urandom_range(1, 32)), int'($urandom_range(1, 32)), 3);
    end

    // Reset mid-job at cycle 8 of a 3x2 run
    load_3x2();
    @(negedge clk);
    cfg = {20'd0, 6'd2, 6'd3};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("midrst_memX_addr", 64'(memX_addr), 64'd0);
    check("midrst_memY_addr", 64'(memY_addr), 64'd0);
    check("midrst_memZ_addr", 64'(memZ_addr), 64'd0);
    check("midrst_dataZ", 64'(dataZ), 64'd0);
    check("midrst_writeZ", 64'(writeZ), 64'd0);
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_done", 64'(done_out), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("postrst_done", 64'(done_out), 64'd0);
      check("postrst_busy", 64'(busy_out), 64'd0);
      check("postrst_writeZ", 64'(writeZ), 64'd0);
    end
    $display("reset mid-job: outputs cleared, no done afterwards");

    // Fresh 3x2 job with a start pulse while busy
    run_job(3, 2, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
